// File: rtl/debug_scan_controller.sv
// Debug-mux scan sequencer: selects each membrane-potential code, then spike layers 1..3, and forwards every sampled byte to the host link.
// Optional macro DEBUG_SCAN_TAG_EN: each data byte is preceded by its select code on the link.
module debug_scan_controller #(
   parameter int SETTLE_CYCLES = 1,
   parameter int NUM_MP        = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] debug_data_in,
   output logic [7:0] debug_config_out,
   output logic       debug_en,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       done
);
   localparam logic [5:0] MP_CNT      = 6'(NUM_MP);
   localparam logic [5:0] LAST_IDX    = 6'(NUM_MP + 2);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_SEND   = 3'd4,
      S_DONE   = 3'd5
`ifdef DEBUG_SCAN_TAG_EN
      , S_TAG  = 3'd6
`endif
   } state_t;

   // Indices past the MP range map onto the spike-layer codes 0x1E..0x20.
   function automatic logic [7:0] code_of(input logic [5:0] idx);
      logic [7:0] w_code;
      if (idx < MP_CNT) begin
         w_code = {2'b00, idx};
      end else begin
         w_code = {2'b00, idx} - {2'b00, MP_CNT} + 8'h1E;
      end
      return w_code;
   endfunction

   state_t     r_state, w_next_state;
   logic [5:0] r_idx, w_next_idx;
   logic [3:0] r_cnt, w_next_cnt;
   logic       r_abort_pend, w_next_abort_pend;
   logic       w_handshake;
   logic [7:0] r_cfg;
   logic       r_en;
   logic [7:0] r_tx_data;
   logic       r_tx_valid;
   logic       r_busy;
   logic       r_done;
`ifdef DEBUG_SCAN_TAG_EN
   logic [7:0] r_data_buf;
`endif

   // Next-state logic; an abort seen while a byte is offered is parked until its handshake.
   always_comb begin
      w_next_state      = r_state;
      w_next_idx        = r_idx;
      w_next_cnt        = r_cnt;
      w_next_abort_pend = r_abort_pend;
      w_handshake       = r_tx_valid & tx_ready;
      case (r_state)
         S_IDLE: begin
            w_next_abort_pend = 1'b0;
            if (start) begin
               w_next_state = S_LOAD;
               w_next_idx   = 6'd0;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_LOAD: begin
            if (abort) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_SETTLE;
               w_next_cnt   = SETTLE_LOAD;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               w_next_state = S_DONE;
            end else if (r_cnt == 4'd0) begin
               w_next_state = S_SAMPLE;
            end else begin
               w_next_cnt = r_cnt - 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               w_next_state = S_DONE;
            end else begin
`ifdef DEBUG_SCAN_TAG_EN
               w_next_state = S_TAG;
`else
               w_next_state = S_SEND;
`endif
            end
         end
`ifdef DEBUG_SCAN_TAG_EN
         S_TAG: begin
            if (w_handshake) begin
               if (abort || r_abort_pend) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_SEND;
               end
            end else begin
               w_next_abort_pend = r_abort_pend | abort;
            end
         end
`endif
         S_SEND: begin
            if (w_handshake) begin
               if (abort || r_abort_pend || (r_idx == LAST_IDX)) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_idx   = r_idx + 6'd1;
                  w_next_state = S_LOAD;
               end
            end else begin
               w_next_abort_pend = r_abort_pend | abort;
            end
         end
         S_DONE: begin
            w_next_state      = S_IDLE;
            w_next_abort_pend = 1'b0;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; outputs are decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 6'd0;
         r_cnt        <= 4'd0;
         r_abort_pend <= 1'b0;
         r_cfg        <= 8'h00;
         r_en         <= 1'b0;
         r_tx_data    <= 8'h00;
         r_tx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef DEBUG_SCAN_TAG_EN
         r_data_buf   <= 8'h00;
`endif
      end else begin
         r_state      <= w_next_state;
         r_idx        <= w_next_idx;
         r_cnt        <= w_next_cnt;
         r_abort_pend <= w_next_abort_pend;
         r_busy       <= (w_next_state != S_IDLE);
         r_done       <= (w_next_state == S_DONE);
         r_en         <= (w_next_state == S_LOAD);
         if (w_next_state == S_LOAD) begin
            r_cfg <= code_of(w_next_idx);
         end
`ifdef DEBUG_SCAN_TAG_EN
         r_tx_valid <= (w_next_state == S_SEND) || (w_next_state == S_TAG);
         if (r_state == S_SAMPLE) begin
            r_tx_data  <= r_cfg;
            r_data_buf <= debug_data_in;
         end else if ((r_state == S_TAG) && w_handshake) begin
            r_tx_data <= r_data_buf;
         end
`else
         r_tx_valid <= (w_next_state == S_SEND);
         if (r_state == S_SAMPLE) begin
            r_tx_data <= debug_data_in;
         end
`endif
      end
   end

   assign debug_config_out = r_cfg;
   assign debug_en         = r_en;
   assign tx_data          = r_tx_data;
   assign tx_valid         = r_tx_valid;
   assign busy             = r_busy;
   assign done             = r_done;
endmodule
